// File: rtl/stream_min_max_pkg.sv
// Shared types for the stream_min_max block.
package stream_min_max_pkg;

  // Frame-tracking FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/comparator_lt.sv
// Signed less-than comparator: lt = (a < b) for two's-complement operands.
module comparator_lt #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  // Signed compare so the most negative value orders below everything else.
  assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/stream_min_max.sv
// Per-frame running min/max/count over a valid/ready stream of signed samples.
// Emits one result record per frame on a valid/ready output.
module stream_min_max
  import stream_min_max_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       min,
  output logic [N-1:0]       max,
  output logic [COUNT_W-1:0] count,
  output logic               sat
);

  state_t state;
  logic   lt_min;
  logic   lt_max;
  logic   first;
  logic   full;

  comparator_lt #(
    .N (N)
  ) u_lt_min (
    .a  (in_data),
    .b  (min),
    .lt (lt_min)
  );

  comparator_lt #(
    .N (N)
  ) u_lt_max (
    .a  (max),
    .b  (in_data),
    .lt (lt_max)
  );

  // No input reaches an output combinationally; handshakes decode from state.
  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_REPORT);
  assign first     = (count == '0);
  assign full      = (count == '1);

  // Frame FSM plus min/max/count/sat update; S_REPORT holds the record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      min   <= '0;
      max   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            min   <= '0;
            max   <= '0;
            count <= '0;
            sat   <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            if (first) begin
              min <= in_data;
              max <= in_data;
            end else begin
              if (lt_min) min <= in_data;
              if (lt_max) max <= in_data;
            end
            // Count sticks at all-ones; further accepts only flag saturation.
            if (full) begin
              sat <= 1'b1;
            end else begin
              count <= count + COUNT_W'(1);
            end
            if (in_last) state <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
